// File: rtl/jtflane_romcache_pkg.sv
// Shared constants, FSM encoding and tag-width helper for the main ROM line cache.
package jtflane_romcache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = 8;
    localparam int BYTE_SEL_W = $clog2(LINE_BYTES);
    localparam int WORD_SEL_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_t;

    // Tag is everything above the byte-in-line select.
    function automatic int tag_width(input int aw);
        return aw - BYTE_SEL_W;
    endfunction

endpackage

// File: rtl/jtflane_romcache_line.sv
// One cache entry: valid bit, tag, four 16-bit words, tag compare and a word write port.
module jtflane_romcache_line
    import jtflane_romcache_pkg::*;
#(
    parameter int TW = 14
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_alloc,
    input  logic [TW-1:0]         i_alloc_tag,
    input  logic                  i_wr,
    input  logic [WORD_SEL_W-1:0] i_wr_idx,
    input  logic [15:0]           i_wr_data,
    input  logic                  i_set_valid,
    input  logic [TW-1:0]         i_cmp_tag,
    input  logic [WORD_SEL_W-1:0] i_rd_idx,
    output logic                  o_hit,
    output logic [15:0]           o_word
);

    logic          r_valid;
    logic [TW-1:0] r_tag;
    logic [15:0]   r_words [LINE_WORDS];

    // Valid/tag: allocation invalidates and retags, last word of a fill validates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else if (i_alloc) begin
            r_valid <= 1'b0;
            r_tag   <= i_alloc_tag;
        end else if (i_set_valid) begin
            r_valid <= 1'b1;
        end
    end

    // Word storage; contents are only trusted once r_valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_words[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_cmp_tag);
    assign o_word = r_words[i_rd_idx];

endmodule

// File: rtl/jtflane_romcache.sv
// Main-CPU ROM responder: serves byte reads from a burst SDRAM port through line entries.
// Optional feature macro: JTFLANE_PREFETCH_EN (two entries, LRU replacement, next-line prefetch).
module jtflane_romcache
    import jtflane_romcache_pkg::*;
#(
    parameter int                  AW       = 17,
    parameter int                  SDRAM_AW = 22,
    parameter logic [SDRAM_AW-1:0] OFFSET   = '0
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                rom_cs,
    input  logic [AW-1:0]       rom_addr,
    output logic [7:0]          rom_data,
    output logic                rom_ok,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                sdram_dst,
    input  logic                sdram_rdy,
    input  logic [15:0]         data_read
);

    localparam int TW = tag_width(AW);
`ifdef JTFLANE_PREFETCH_EN
    localparam int NENT = 2;
`else
    localparam int NENT = 1;
`endif

    // Request-side decode
    logic [TW-1:0]         w_tag_in;
    logic [WORD_SEL_W-1:0] w_rd_idx;
    logic [NENT-1:0]       w_line_hit;
    logic [15:0]           w_line_word [NENT];
    logic                  w_hit_cs;
    logic                  w_miss;
    logic [15:0]           w_hit_word;

    // FSM and fill bookkeeping
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_alloc;
    logic                  w_alloc_idx;
    logic [TW-1:0]         w_alloc_tag;
    logic [SDRAM_AW-1:0]   w_alloc_base;
    logic                  w_fill_wr;
    logic                  w_fill_done;
    logic                  r_fill_idx;
    logic [WORD_SEL_W-1:0] r_cnt;
    logic [SDRAM_AW-1:0]   r_sdram_addr;

    // Output registers
    logic                  r_ok;
    logic [AW-1:0]         r_addr;
    logic [15:0]           r_word;

`ifdef JTFLANE_PREFETCH_EN
    logic                  r_lru;
    logic                  w_hit_idx;
    logic                  r_pf_pending;
    logic                  r_fill_is_pf;
    logic                  w_is_pf;
    logic [TW-1:0]         r_fill_tag;
`endif

    assign w_tag_in = rom_addr[AW-1:BYTE_SEL_W];
    assign w_rd_idx = rom_addr[BYTE_SEL_W-1:1];

    generate
        for (genvar gi = 0; gi < NENT; gi++) begin : g_line
            jtflane_romcache_line #(
                .TW (TW)
            ) u_line (
                .clk         (clk),
                .rst         (rst),
                .i_alloc     (w_alloc && (w_alloc_idx == 1'(gi))),
                .i_alloc_tag (w_alloc_tag),
                .i_wr        (w_fill_wr && (r_fill_idx == 1'(gi))),
                .i_wr_idx    (r_cnt),
                .i_wr_data   (data_read),
                .i_set_valid (w_fill_done && (r_fill_idx == 1'(gi))),
                .i_cmp_tag   (w_tag_in),
                .i_rd_idx    (w_rd_idx),
                .o_hit       (w_line_hit[gi]),
                .o_word      (w_line_word[gi])
            );
        end
    endgenerate

    assign w_hit_cs = rom_cs && (|w_line_hit);
    assign w_miss   = rom_cs && !(|w_line_hit);

    // Select the word of whichever entry hits (entries never share a valid tag in practice).
    always_comb begin
        w_hit_word = w_line_word[0];
        for (int i = 1; i < NENT; i++) begin
            if (w_line_hit[i]) begin
                w_hit_word = w_line_word[i];
            end
        end
    end

`ifdef JTFLANE_PREFETCH_EN
    assign w_hit_idx = w_line_hit[1];

    // LRU points at the entry that was not hit most recently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lru <= 1'b0;
        end else if (w_hit_cs) begin
            r_lru <= ~w_hit_idx;
        end
    end
`endif

    // Burst start word address for a line tag.
    assign w_alloc_base = {{(SDRAM_AW-TW-WORD_SEL_W){1'b0}}, w_alloc_tag, {WORD_SEL_W{1'b0}}};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus allocate/write strobes; demand misses beat a pending prefetch.
    always_comb begin
        w_state_next = r_state;
        w_alloc      = 1'b0;
        w_alloc_idx  = 1'b0;
        w_alloc_tag  = w_tag_in;
        w_fill_wr    = 1'b0;
        w_fill_done  = 1'b0;
`ifdef JTFLANE_PREFETCH_EN
        w_is_pf      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_alloc      = 1'b1;
`ifdef JTFLANE_PREFETCH_EN
                    w_alloc_idx  = r_lru;
`endif
                    w_state_next = ST_REQ;
                end
`ifdef JTFLANE_PREFETCH_EN
                else if (r_pf_pending) begin
                    w_alloc      = 1'b1;
                    w_alloc_idx  = ~r_fill_idx;
                    w_alloc_tag  = r_fill_tag + 1'b1;
                    w_is_pf      = 1'b1;
                    w_state_next = ST_REQ;
                end
`endif
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sdram_dst) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (sdram_rdy) begin
                    w_fill_wr = 1'b1;
                    if (r_cnt == WORD_SEL_W'(LINE_WORDS - 1)) begin
                        w_fill_done  = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Fill target, burst address and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_idx   <= 1'b0;
            r_cnt        <= '0;
            r_sdram_addr <= OFFSET;
        end else begin
            if (w_alloc) begin
                r_fill_idx   <= w_alloc_idx;
                r_sdram_addr <= OFFSET + w_alloc_base;
            end
            if (r_state == ST_WAIT && sdram_dst) begin
                r_cnt <= '0;
            end else if (w_fill_wr) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef JTFLANE_PREFETCH_EN
    // A completed demand fill arms one next-line prefetch; any new allocation disarms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pf_pending <= 1'b0;
            r_fill_is_pf <= 1'b0;
            r_fill_tag   <= '0;
        end else begin
            if (w_alloc) begin
                r_pf_pending <= 1'b0;
                r_fill_is_pf <= w_is_pf;
                r_fill_tag   <= w_alloc_tag;
            end else if (w_fill_done) begin
                r_pf_pending <= ~r_fill_is_pf;
            end
        end
    end
`endif

    // Register hit word and address; the compare below kills stale ok on address change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ok   <= 1'b0;
            r_addr <= '0;
            r_word <= '0;
        end else begin
            r_ok <= w_hit_cs;
            if (w_hit_cs) begin
                r_addr <= rom_addr;
                r_word <= w_hit_word;
            end
        end
    end

    assign rom_ok     = r_ok && rom_cs && (r_addr == rom_addr);
    assign rom_data   = r_addr[0] ? r_word[15:8] : r_word[7:0];
    assign sdram_req  = (r_state == ST_REQ);
    assign sdram_addr = r_sdram_addr;

endmodule

// File: tb/tb_jtflane_romcache.sv
// Scoreboard bench for jtflane_romcache: stimulus queues expected reads/requests, monitor checks them.
module tb_jtflane_romcache;

    localparam int          AW       = 17;
    localparam int          SDRAM_AW = 22;
    localparam logic [21:0] OFFSET   = 22'h100000;

    logic                clk = 1'b0;
    logic                rst;
    logic                rom_cs;
    logic [AW-1:0]       rom_addr;
    logic [7:0]          rom_data;
    logic                rom_ok;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic                sdram_req;
    logic                sdram_ack;
    logic                sdram_dst;
    logic                sdram_rdy;
    logic [15:0]         data_read;

    jtflane_romcache #(
        .AW       (AW),
        .SDRAM_AW (SDRAM_AW),
        .OFFSET   (OFFSET)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dst  (sdram_dst),
        .sdram_rdy  (sdram_rdy),
        .data_read  (data_read)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [7:0] data; int cyc; } rd_exp_t;
    typedef struct { logic [21:0] addr; int cyc; } rq_exp_t;
    rd_exp_t rd_q[$];
    rq_exp_t rq_q[$];
    rd_exp_t mon_rd;
    rq_exp_t mon_rq;
    logic    prev_ok  = 1'b0;
    logic    prev_req = 1'b0;
    int      ack_cyc  = -10;

    // Monitor: compares every rising rom_ok and sdram_req against the queued expectations.
    always @(negedge clk) begin
        if (rst) begin
            prev_ok  = 1'b0;
            prev_req = 1'b0;
        end else begin
            if (sdram_ack) ack_cyc = cyc;
            if (rom_ok && !prev_ok) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected addr=%h data=%h cyc=%0d required=no rom_ok", rom_addr, rom_data, cyc);
                end else begin
                    mon_rd = rd_q.pop_front();
                    if (rom_data !== mon_rd.data || cyc != mon_rd.cyc) begin
                        failures++;
                        $display("FAIL rd addr=%h data=%h cyc=%0d required data=%h cyc=%0d", rom_addr, rom_data, cyc, mon_rd.data, mon_rd.cyc);
                    end else begin
                        $display("rd   addr=%h data=%h cyc=%0d ok", rom_addr, rom_data, cyc);
                    end
                end
            end
            if (sdram_req && !prev_req) begin
                checks++;
                if (rq_q.size() == 0) begin
                    failures++;
                    $display("FAIL req_unexpected sdram_addr=%h cyc=%0d required=no request", sdram_addr, cyc);
                end else begin
                    mon_rq = rq_q.pop_front();
                    if (sdram_addr !== mon_rq.addr || cyc != mon_rq.cyc) begin
                        failures++;
                        $display("FAIL req sdram_addr=%h cyc=%0d required addr=%h cyc=%0d", sdram_addr, cyc, mon_rq.addr, mon_rq.cyc);
                    end else begin
                        $display("req  sdram_addr=%h cyc=%0d ok", sdram_addr, cyc);
                    end
                end
            end
            if (!sdram_req && prev_req) begin
                checks++;
                if (cyc != ack_cyc + 1) begin
                    failures++;
                    $display("FAIL req_fall cyc=%0d required=%0d", cyc, ack_cyc + 1);
                end else begin
                    $display("req  released cyc=%0d ok", cyc);
                end
            end
            prev_ok  = rom_ok;
            prev_req = sdram_req;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end else begin
            $display("chk  %s value=%h ok", name, got);
        end
    endtask

    task automatic exp_rd(input logic [7:0] d, input int c);
        rd_exp_t e;
        e.data = d;
        e.cyc  = c;
        rd_q.push_back(e);
    endtask

    task automatic exp_rq(input logic [21:0] a, input int c);
        rq_exp_t e;
        e.addr = a;
        e.cyc  = c;
        rq_q.push_back(e);
    endtask

    // Present a read; a miss shows sdram_req one cycle later.
    task automatic present(input logic [AW-1:0] a);
        rom_cs   = 1'b1;
        rom_addr = a;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!sdram_req && n < 40) begin
            tick();
            n++;
        end
        if (!sdram_req) begin
            checks++;
            failures++;
            $display("FAIL req_timeout sdram_req=0 required=1 within 40 cycles");
        end
    endtask

    task automatic serve_head();
        wait_req();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        sdram_dst = 1'b1;
        tick();
        sdram_dst = 1'b0;
    endtask

    task automatic rdy_word(input logic [15:0] w, output int c);
        data_read = w;
        sdram_rdy = 1'b1;
        c = cyc;
        tick();
        sdram_rdy = 1'b0;
        data_read = 16'h0;
    endtask

    // Full burst; c4 is the cycle the fourth rdy is presented.
    task automatic serve(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3, output int c4);
        serve_head();
        rdy_word(w0, c4); tick();
        rdy_word(w1, c4); tick();
        rdy_word(w2, c4); tick();
        rdy_word(w3, c4);
    endtask

    // Stray strobes with the CPU idle must not touch the cache; then reread a cached byte.
    task automatic spurious(input logic [AW-1:0] a, input logic [7:0] d);
        int c;
        rom_cs = 1'b0;
        tick();
        sdram_dst = 1'b1; tick(); sdram_dst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdy_word(16'hDEAD, c);
        end
        tick(2);
        chk("spurious_no_req", {31'd0, sdram_req}, 32'd0);
        present(a);
        exp_rd(d, cyc + 1);
        tick(3);
    endtask

    initial begin
        int c4;
        int c5;
        rst = 1'b1; rom_cs = 1'b0; rom_addr = '0;
        sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_rdy = 1'b0; data_read = 16'h0;
        tick(3);
        chk("reset_rom_ok", {31'd0, rom_ok}, 32'd0);
        chk("reset_rom_data", {24'd0, rom_data}, 32'd0);
        chk("reset_sdram_req", {31'd0, sdram_req}, 32'd0);
        chk("reset_sdram_addr", {10'd0, sdram_addr}, {10'd0, OFFSET});
        rst = 1'b0;
        tick();

`ifndef JTFLANE_PREFETCH_EN
        // Cold read, then a hit in the same line.
        present(17'h08000);
        exp_rq(OFFSET + 22'h4000, cyc + 1);
        serve(16'h2211, 16'h4433, 16'h6655, 16'h8877, c4);
        exp_rd(8'h11, c4 + 2);
        tick(3);
        rom_addr = 17'h08005;
        #2;
        chk("ok_drops_on_addr_change", {31'd0, rom_ok}, 32'd0);
        exp_rd(8'h66, cyc + 1);
        tick(3);

        // Reset after two rdy: late strobes ignored, reread refetches.
        rom_cs = 1'b0; rst = 1'b1; tick(); rst = 1'b0; tick();
        present(17'h08000);
        exp_rq(OFFSET + 22'h4000, cyc + 1);
        serve_head();
        rdy_word(16'h1111, c4); tick();
        rdy_word(16'h2222, c4); tick();
        rom_cs = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        chk("midburst_rst_req", {31'd0, sdram_req}, 32'd0);
        chk("midburst_rst_ok", {31'd0, rom_ok}, 32'd0);
        chk("midburst_rst_data", {24'd0, rom_data}, 32'd0);
        rdy_word(16'hBAD0, c4); tick();
        rdy_word(16'hBAD1, c4); tick(2);
        chk("late_rdy_no_req", {31'd0, sdram_req}, 32'd0);
        present(17'h08000);
        exp_rq(OFFSET + 22'h4000, cyc + 1);
        serve(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, c4);
        exp_rd(8'hB2, c4 + 2);
        tick(3);
        rom_addr = 17'h08007;
        exp_rd(8'h07, cyc + 1);
        tick(3);

        // Evict, then switch address mid-fill of 17'h08000.
        present(17'h10000);
        exp_rq(OFFSET + 22'h8000, cyc + 1);
        serve(16'h0102, 16'h0304, 16'h0506, 16'h0708, c4);
        exp_rd(8'h02, c4 + 2);
        tick(3);
        present(17'h08000);
        exp_rq(OFFSET + 22'h4000, cyc + 1);
        serve_head();
        rdy_word(16'h2211, c4); tick();
        rom_addr = 17'h08100;
        rdy_word(16'h4433, c4); tick();
        rdy_word(16'h6655, c4); tick();
        rdy_word(16'h8877, c4);
        exp_rq(OFFSET + 22'h4080, c4 + 2);
        serve(16'h3130, 16'h3332, 16'h3534, 16'h3736, c5);
        exp_rd(8'h30, c5 + 2);
        tick(3);

        spurious(17'h08103, 8'h33);
        rom_addr = 17'h08106;
        exp_rd(8'h36, cyc + 1);
        tick(3);
`else
        // Fill of the top line prefetches the wrapped line 0 into the other entry.
        present(17'h1FFF8);
        exp_rq(OFFSET + 22'h0FFFC, cyc + 1);
        serve(16'h5A4B, 16'h7C6D, 16'h9E8F, 16'hB0A1, c4);
        exp_rd(8'h4B, c4 + 2);
        exp_rq(OFFSET, c4 + 2);
        serve(16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978, c5);
        tick(3);
        present(17'h00000);
        exp_rd(8'h1E, cyc + 1);
        tick(3);
        rom_addr = 17'h1FFFD;
        exp_rd(8'h9E, cyc + 1);
        tick(3);
        spurious(17'h00003, 8'h2D);
`endif

        rom_cs = 1'b0;
        tick(3);
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        chk("req_queue_drained", rq_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
